// File: rtl/imem_loader.sv
// Byte-stream loader that writes big-endian 32-bit words into instruction memory and holds the CPU until done.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-2:0] word_count,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            dbg_state
);

    localparam int IDX_W       = ADDR_WIDTH - 2;
    localparam int MAX_WORDS_I = 2 ** IDX_W;
    localparam logic [ADDR_WIDTH-2:0] MAX_WORDS = MAX_WORDS_I[ADDR_WIDTH-2:0];
    localparam logic [IDX_W-1:0]      IDX_ONE   = 1;

    // Byte link: a byte moves on a cycle where in_valid and in_ready are both high;
    // in_ready depends only on the current state, never on in_valid.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [IDX_W-1:0] word_last_q, word_last_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      assemble_q, assemble_d;
    logic             done_q, done_d;
    logic             cpu_hold_q, cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        word_last_d = word_last_q;
        byte_cnt_d  = byte_cnt_q;
        assemble_d  = assemble_q;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    word_idx_d  = '0;
                    byte_cnt_d  = '0;
                    // Oversized requests are clamped so the last address never wraps.
                    word_last_d = (word_count >= MAX_WORDS) ? '1 : (word_count[IDX_W-1:0] - IDX_ONE);
                    state_d     = (word_count == '0) ? S_DONE : S_RECV;
`ifdef LOADER_CHECKSUM_EN
                    csum_d      = '0;
                    err_d       = 1'b0;
`endif
                end
            end
            S_RECV: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    assemble_d = {assemble_q[23:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ in_data;
`endif
                    if (byte_cnt_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we     = 1'b1;
                byte_cnt_d = '0;
                if (word_idx_q == word_last_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    word_idx_d = word_idx_q + IDX_ONE;
                    state_d    = S_RECV;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // A start seen in DONE drops done on the very next cycle, ahead of the state change.
        done_d     = (state_q == S_DONE) && !start;
        cpu_hold_d = !done_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            word_idx_q  <= '0;
            word_last_q <= '0;
            byte_cnt_q  <= '0;
            assemble_q  <= '0;
            done_q      <= 1'b0;
            cpu_hold_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            word_last_q <= word_last_d;
            byte_cnt_q  <= byte_cnt_d;
            assemble_q  <= assemble_d;
            done_q      <= done_d;
            cpu_hold_q  <= cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
            err_q       <= err_d;
`endif
        end
    end

    assign mem_addr  = (state_q == S_WRITE) ? {word_idx_q, 2'b00} : '0;
    assign mem_wdata = (state_q == S_WRITE) ? assemble_q : '0;
    assign done      = done_q;
    assign cpu_hold  = cpu_hold_q;
    assign dbg_state = state_q;
`ifdef LOADER_CHECKSUM_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: drivers issue byte loads, a monitor checks every memory write.
module tb_imem_loader;

    localparam int AW   = 8;
    localparam int MAXW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-2:0] word_count = '0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [2:0]    dbg_state;

    int errors = 0;
    int checks = 0;
    int we_count = 0;
    logic [39:0] exp_q[$];
    logic [7:0]  prog_q[$];
    logic [39:0] mon_e;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(rst_n), .start(start), .word_count(word_count),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected (addr, data) pair.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            we_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h with no write expected", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr_data", {mem_addr, mem_wdata}, mon_e);
            end
            check("ready_low_in_write", {39'd0, in_ready}, 40'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        word_count = n[AW-2:0];
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data = b;
        while (!in_ready && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: in_ready stayed 0 for byte %h", b);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_data = 8'($urandom_range(0, 255));
    endtask

    // Reference: word i of the program is bytes 4i..4i+3, first byte most significant, at byte address 4i.
    task automatic run_load(input int n, input int gmin, input int gmax);
        int nw, w0, t, g;
        logic [7:0] x;
        nw = (n > MAXW) ? MAXW : n;
        for (int i = 0; i < nw; i++)
            exp_q.push_back({8'(4 * i), prog_q[4*i], prog_q[4*i+1], prog_q[4*i+2], prog_q[4*i+3]});
        w0 = we_count;
        do_start(n);
        x = 8'h00;
        for (int i = 0; i < 4 * nw; i++) begin
            x = x ^ prog_q[i];
            send_byte(prog_q[i]);
            g = $urandom_range(gmin, gmax);
            repeat (g) tick();
        end
`ifdef LOADER_CHECKSUM_EN
        if (nw > 0) send_byte(x);
`endif
        t = 0;
        while (!done && t < 50) begin
            tick();
            t++;
        end
        check("done_after_load", {39'd0, done}, 40'd1);
        check("cpu_hold_after_load", {39'd0, cpu_hold}, 40'd0);
        check("err_after_load", {39'd0, err}, 40'd0);
        check("write_count", 40'(we_count - w0), 40'(nw));
    endtask

    task automatic fill_random(input int nbytes);
        prog_q.delete();
        for (int i = 0; i < nbytes; i++) prog_q.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int w0, n;

        // Reset state
        repeat (3) tick();
        check("rst_cpu_hold", {39'd0, cpu_hold}, 40'd1);
        check("rst_done", {39'd0, done}, 40'd0);
        check("rst_in_ready", {39'd0, in_ready}, 40'd0);
        check("rst_mem_we", {39'd0, mem_we}, 40'd0);
        check("rst_mem_addr", {32'd0, mem_addr}, 40'd0);
        check("rst_mem_wdata", {8'd0, mem_wdata}, 40'd0);
        check("rst_err", {39'd0, err}, 40'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_cpu_hold", {39'd0, cpu_hold}, 40'd1);
        check("idle_in_ready", {39'd0, in_ready}, 40'd0);

        // Two words back-to-back, then the same with 3-cycle gaps
        prog_q = '{8'hE3, 8'hA0, 8'h10, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
        run_load(2, 0, 0);
        run_load(2, 3, 3);

        // Bytes offered while DONE are refused
        in_valid = 1'b1;
        in_data = 8'h5A;
        repeat (3) tick();
        check("done_refuses_bytes", {39'd0, in_ready}, 40'd0);
        in_valid = 1'b0;

        // Zero-word load: done clears next cycle, reasserts one cycle later
        w0 = we_count;
        do_start(0);
        check("zero_done_cleared", {38'd0, done, cpu_hold}, 40'd1);
        tick();
        check("zero_done_set", {38'd0, done, cpu_hold}, 40'd2);
        check("zero_no_write", 40'(we_count - w0), 40'd0);

        // Reset in the middle of a word: no write, then a clean reload
        do_start(1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {39'd0, in_ready}, 40'd0);
        check("midrst_cpu_hold", {39'd0, cpu_hold}, 40'd1);
        check("midrst_done", {39'd0, done}, 40'd0);
        tick();
        rst_n = 1'b1;
        tick();
        prog_q = '{8'hC0, 8'hFF, 8'hEE, 8'h11};
        run_load(1, 0, 0);

        prog_q = '{8'h01, 8'h02, 8'h04, 8'h08};
        run_load(1, 0, 1);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: write still lands, then err with the CPU held
        exp_q.push_back({8'h00, 32'h01020408});
        do_start(1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h04);
        send_byte(8'h08);
        send_byte(8'h0E);
        tick();
        check("csum_bad_err", {39'd0, err}, 40'd1);
        check("csum_bad_hold", {39'd0, cpu_hold}, 40'd1);
        check("csum_bad_done", {39'd0, done}, 40'd0);
        prog_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(1, 0, 0);
`endif

        // Random loads with random gaps
        repeat (6) begin
            n = $urandom_range(1, 8);
            fill_random(4 * n);
            run_load(n, 0, 2);
        end

        // Oversized request is clamped to the memory size
        fill_random(4 * MAXW);
        run_load(100, 0, 0);

        repeat (3) tick();
        check("queue_empty", 40'(exp_q.size()), 40'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
